// File: rtl/store_queue.sv
// ----------------------------------------------------------------------------
// store_queue
//
// In-order store queue for the out-of-order core. Entries are allocated at
// dispatch, receive address/data when the LSU executes the store, are marked
// committed by the ROB, and committed+executed entries drain in order to the
// data memory port.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   alloc_*                 dispatch allocation; alloc_sqid_o is the current tail
//   exec_*                  LSU address/data/size capture for an allocated entry
//   commit_valid_i          thermometer-coded commit of the oldest uncommitted
//   flush_i                 drop every uncommitted entry
//   mem_req_*               valid/ready store request for the head entry
//   count_o/empty_o/full_o  occupancy
//   err_o                   one-cycle pulse on a protocol violation
//
// Optional build macro STORE_QUEUE_FWD_EN adds store-to-load forwarding
// ports ld_* (load lookup) and fwd_* (hit, full cover, lane-aligned data).
// ----------------------------------------------------------------------------
module store_queue #(
   parameter int unsigned NR_ENTRIES      = 16,
   parameter int unsigned NR_COMMIT_PORTS = 1,
   parameter int unsigned XLEN            = 64,
   parameter int unsigned ID_BITS         = 20,
   parameter int unsigned IDX_W           = $clog2(NR_ENTRIES)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,

   input  logic                       alloc_valid_i,
   input  logic [ID_BITS-1:0]         alloc_id_i,
   output logic                       alloc_ready_o,
   output logic [IDX_W-1:0]           alloc_sqid_o,

   input  logic                       exec_valid_i,
   input  logic [IDX_W-1:0]           exec_sqid_i,
   input  logic [XLEN-1:0]            exec_addr_i,
   input  logic [XLEN-1:0]            exec_data_i,
   input  logic [1:0]                 exec_size_i,

   input  logic [NR_COMMIT_PORTS-1:0] commit_valid_i,
   input  logic                       flush_i,

   output logic                       mem_req_valid_o,
   input  logic                       mem_req_ready_i,
   output logic [XLEN-1:0]            mem_req_addr_o,
   output logic [XLEN-1:0]            mem_req_data_o,
   output logic [XLEN/8-1:0]          mem_req_be_o,
   output logic [ID_BITS-1:0]         mem_req_id_o,

`ifdef STORE_QUEUE_FWD_EN
   input  logic                       ld_valid_i,
   input  logic [XLEN-1:0]            ld_addr_i,
   input  logic [1:0]                 ld_size_i,
   input  logic [IDX_W:0]             ld_sqid_i,
   output logic                       fwd_hit_o,
   output logic                       fwd_full_o,
   output logic [XLEN-1:0]            fwd_data_o,
`endif

   output logic [IDX_W:0]             count_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       err_o
);

   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);

   localparam logic [1:0] SIZE_D = 2'd0;
   localparam logic [1:0] SIZE_W = 2'd1;
   localparam logic [1:0] SIZE_H = 2'd2;
   localparam logic [1:0] SIZE_B = 2'd3;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [IDX_W-1:0] sq_id_t;

   // Byte-enable pattern of an access, placed at its byte offset. Bytes that
   // fall off the top of the word are truncated.
   function automatic logic [BE_W-1:0] be_of(input logic [1:0]       size,
                                             input logic [OFF_W-1:0] off);
      logic [BE_W-1:0] mask;
      case (size)
         SIZE_D:  mask = '1;
         SIZE_W:  mask = BE_W'(8'h0F);
         SIZE_H:  mask = BE_W'(8'h03);
         default: mask = BE_W'(8'h01);
      endcase
      return mask << off;
   endfunction

   function automatic logic misaligned(input logic [1:0]       size,
                                       input logic [OFF_W-1:0] off);
      logic [OFF_W-1:0] am;
      case (size)
         SIZE_D:  am = '1;
         SIZE_W:  am = OFF_W'(3);
         SIZE_H:  am = OFF_W'(1);
         SIZE_B:  am = '0;
         default: am = '0;
      endcase
      return |(off & am);
   endfunction

   // Pointers and flags
   ptr_t                  head_q, head_d;
   ptr_t                  cmt_q,  cmt_d;
   ptr_t                  tail_q, tail_d;
   logic [NR_ENTRIES-1:0] executed_q,  executed_d;
   logic [NR_ENTRIES-1:0] committed_q, committed_d;
   logic                  err_q, err_d;

   // Payload (not reset; only read behind valid flags)
   logic [ID_BITS-1:0]    id_q   [NR_ENTRIES];
   logic [ID_BITS-1:0]    id_d   [NR_ENTRIES];
   logic [XLEN-1:0]       addr_q [NR_ENTRIES];
   logic [XLEN-1:0]       addr_d [NR_ENTRIES];
   logic [XLEN-1:0]       data_q [NR_ENTRIES];
   logic [XLEN-1:0]       data_d [NR_ENTRIES];
   logic [1:0]            size_q [NR_ENTRIES];
   logic [1:0]            size_d [NR_ENTRIES];

   sq_id_t                head_idx, cmt_idx, tail_idx;
   ptr_t                  count, uncmt_cnt;
   logic [OFF_W-1:0]      head_off;
   logic                  drain_fire;

   sq_id_t                exec_off;
   logic                  exec_in_range;

   logic [NR_COMMIT_PORTS-1:0] cv_inc;
   logic                  therm_ok;
   ptr_t                  n_req, n_eff;

   assign head_idx  = head_q[IDX_W-1:0];
   assign cmt_idx   = cmt_q[IDX_W-1:0];
   assign tail_idx  = tail_q[IDX_W-1:0];
   assign count     = tail_q - head_q;
   assign uncmt_cnt = tail_q - cmt_q;

   assign full_o        = (tail_idx == head_idx) && (tail_q[IDX_W] != head_q[IDX_W]);
   assign empty_o       = (tail_q == head_q);
   assign count_o       = count;
   assign alloc_ready_o = !full_o;
   assign alloc_sqid_o  = tail_idx;
   assign err_o         = err_q;

   // Drain port: purely from registered state, so an asynchronous reset
   // drops the request immediately.
   assign head_off        = addr_q[head_idx][OFF_W-1:0];
   assign mem_req_valid_o = (head_q != cmt_q) && committed_q[head_idx] && executed_q[head_idx];
   assign mem_req_addr_o  = {addr_q[head_idx][XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign mem_req_data_o  = data_q[head_idx] << {head_off, 3'b000};
   assign mem_req_be_o    = be_of(size_q[head_idx], head_off);
   assign mem_req_id_o    = id_q[head_idx];
   assign drain_fire      = mem_req_valid_o && mem_req_ready_i;

   // Exec target must lie in [cmt, tail): allocated and not yet committed.
   assign exec_off      = exec_sqid_i - cmt_idx;
   assign exec_in_range = ({1'b0, exec_off} < uncmt_cnt);

   // Thermometer code: set bits contiguous from bit 0 (x & (x+1) == 0).
   assign cv_inc   = commit_valid_i + NR_COMMIT_PORTS'(1);
   assign therm_ok = ((commit_valid_i & cv_inc) == '0);

   always_comb begin
      n_req = '0;
      for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
         n_req = n_req + PTR_W'(commit_valid_i[k]);
      end
   end

   always_comb begin
      head_d      = head_q;
      cmt_d       = cmt_q;
      tail_d      = tail_q;
      executed_d  = executed_q;
      committed_d = committed_q;
      id_d        = id_q;
      addr_d      = addr_q;
      data_d      = data_q;
      size_d      = size_q;
      err_d       = 1'b0;
      n_eff       = '0;

      // Drain: head slot is strictly older than cmt, so it never collides
      // with the exec/commit/alloc slots below.
      if (drain_fire) begin
         head_d                = head_q + PTR_W'(1);
         executed_d[head_idx]  = 1'b0;
         committed_d[head_idx] = 1'b0;
         if (misaligned(size_q[head_idx], head_off)) begin
            err_d = 1'b1;
         end
      end

      if (exec_valid_i) begin
         if (exec_in_range) begin
            executed_d[exec_sqid_i] = 1'b1;
            addr_d[exec_sqid_i]     = exec_addr_i;
            data_d[exec_sqid_i]     = exec_data_i;
            size_d[exec_sqid_i]     = exec_size_i;
         end else begin
            err_d = 1'b1;
         end
      end

      if (|commit_valid_i) begin
         if (!therm_ok) begin
            err_d = 1'b1;
         end else begin
            n_eff = n_req;
            if (n_req > uncmt_cnt) begin
               err_d = 1'b1;
               n_eff = uncmt_cnt;
            end
            for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
               if (PTR_W'(k) < n_eff) begin
                  committed_d[cmt_idx + IDX_W'(k)] = 1'b1;
                  if (!executed_q[cmt_idx + IDX_W'(k)]) begin
                     err_d = 1'b1;
                  end
               end
            end
            cmt_d = cmt_q + n_eff;
         end
      end

      // Flush uses the post-commit cmt and suppresses any same-cycle alloc.
      if (flush_i) begin
         tail_d = cmt_d;
      end else if (alloc_valid_i && alloc_ready_o) begin
         id_d[tail_idx]        = alloc_id_i;
         executed_d[tail_idx]  = 1'b0;
         committed_d[tail_idx] = 1'b0;
         tail_d                = tail_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q      <= '0;
         cmt_q       <= '0;
         tail_q      <= '0;
         executed_q  <= '0;
         committed_q <= '0;
         err_q       <= 1'b0;
      end else begin
         head_q      <= head_d;
         cmt_q       <= cmt_d;
         tail_q      <= tail_d;
         executed_q  <= executed_d;
         committed_q <= committed_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      id_q   <= id_d;
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
   end

`ifdef STORE_QUEUE_FWD_EN
   // Search [head, ld_sqid) oldest to youngest; the last hit wins, which
   // leaves the youngest matching store selected.
   ptr_t             ld_span;
   logic [BE_W-1:0]  ld_be;
   sq_id_t           f_idx;
   logic [OFF_W-1:0] f_off;
   logic [BE_W-1:0]  f_be;
   logic             fwd_hit;
   logic [BE_W-1:0]  fwd_be;
   logic [XLEN-1:0]  fwd_lane;

   assign ld_span = ld_sqid_i - head_q;
   assign ld_be   = be_of(ld_size_i, ld_addr_i[OFF_W-1:0]);

   always_comb begin
      f_idx    = '0;
      f_off    = '0;
      f_be     = '0;
      fwd_hit  = 1'b0;
      fwd_be   = '0;
      fwd_lane = '0;
      for (int unsigned k = 0; k < NR_ENTRIES; k++) begin
         f_idx = head_idx + IDX_W'(k);
         f_off = addr_q[f_idx][OFF_W-1:0];
         f_be  = be_of(size_q[f_idx], f_off);
         if (ld_valid_i && (PTR_W'(k) < ld_span) && executed_q[f_idx] &&
             (addr_q[f_idx][XLEN-1:OFF_W] == ld_addr_i[XLEN-1:OFF_W]) &&
             (|(f_be & ld_be))) begin
            fwd_hit  = 1'b1;
            fwd_be   = f_be;
            fwd_lane = data_q[f_idx] << {f_off, 3'b000};
         end
      end
   end

   assign fwd_hit_o  = fwd_hit;
   assign fwd_full_o = fwd_hit && ((fwd_be & ld_be) == ld_be);
   assign fwd_data_o = fwd_lane >> {ld_addr_i[OFF_W-1:0], 3'b000};
`endif

endmodule

// File: tb/tb_store_queue.sv
// ----------------------------------------------------------------------------
// tb_store_queue
//
// Scoreboard bench for store_queue (16 entries, 2 commit ports). Stimulus
// pushes the expected memory request whenever it commits a store; a monitor
// on the falling edge compares the stalled and accepted requests against the
// scoreboard front and flags unexpected err_o pulses.
// ----------------------------------------------------------------------------
module tb_store_queue;
   localparam int unsigned NE  = 16;
   localparam int unsigned NC  = 2;
   localparam int unsigned XL  = 64;
   localparam int unsigned IDB = 20;
   localparam int unsigned IW  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           alloc_valid_i;
   logic [IDB-1:0] alloc_id_i;
   logic           alloc_ready_o;
   logic [IW-1:0]  alloc_sqid_o;
   logic           exec_valid_i;
   logic [IW-1:0]  exec_sqid_i;
   logic [XL-1:0]  exec_addr_i;
   logic [XL-1:0]  exec_data_i;
   logic [1:0]     exec_size_i;
   logic [NC-1:0]  commit_valid_i;
   logic           flush_i;
   logic           mem_req_valid_o;
   logic           mem_req_ready_i;
   logic [XL-1:0]  mem_req_addr_o;
   logic [XL-1:0]  mem_req_data_o;
   logic [XL/8-1:0] mem_req_be_o;
   logic [IDB-1:0] mem_req_id_o;
   logic [IW:0]    count_o;
   logic           empty_o;
   logic           full_o;
   logic           err_o;
`ifdef STORE_QUEUE_FWD_EN
   logic           ld_valid_i;
   logic [XL-1:0]  ld_addr_i;
   logic [1:0]     ld_size_i;
   logic [IW:0]    ld_sqid_i;
   logic           fwd_hit_o;
   logic           fwd_full_o;
   logic [XL-1:0]  fwd_data_o;
`endif

   always #5 clk = ~clk;

   store_queue #(
      .NR_ENTRIES      (NE),
      .NR_COMMIT_PORTS (NC),
      .XLEN            (XL),
      .ID_BITS         (IDB)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .alloc_valid_i   (alloc_valid_i),
      .alloc_id_i      (alloc_id_i),
      .alloc_ready_o   (alloc_ready_o),
      .alloc_sqid_o    (alloc_sqid_o),
      .exec_valid_i    (exec_valid_i),
      .exec_sqid_i     (exec_sqid_i),
      .exec_addr_i     (exec_addr_i),
      .exec_data_i     (exec_data_i),
      .exec_size_i     (exec_size_i),
      .commit_valid_i  (commit_valid_i),
      .flush_i         (flush_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_data_o  (mem_req_data_o),
      .mem_req_be_o    (mem_req_be_o),
      .mem_req_id_o    (mem_req_id_o),
`ifdef STORE_QUEUE_FWD_EN
      .ld_valid_i      (ld_valid_i),
      .ld_addr_i       (ld_addr_i),
      .ld_size_i       (ld_size_i),
      .ld_sqid_i       (ld_sqid_i),
      .fwd_hit_o       (fwd_hit_o),
      .fwd_full_o      (fwd_full_o),
      .fwd_data_o      (fwd_data_o),
`endif
      .count_o         (count_o),
      .empty_o         (empty_o),
      .full_o          (full_o),
      .err_o           (err_o)
   );

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
      logic [19:0] id;
   } req_t;

   req_t        exp_q[$];
   int unsigned errors = 0;
   int unsigned checks = 0;
   bit          err_ok = 1'b0;
   bit          rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference request for a store, from the size table and byte offset.
   function automatic req_t model(input logic [63:0] a, input logic [63:0] d,
                                  input logic [1:0] s, input logic [19:0] id);
      req_t        r;
      logic [7:0]  m;
      logic [15:0] wide;
      int unsigned off;
      off = int'(a[2:0]);
      case (s)
         2'd0:    m = 8'hFF;
         2'd1:    m = 8'h0F;
         2'd2:    m = 8'h03;
         default: m = 8'h01;
      endcase
      wide   = {8'h00, m} << off;
      r.addr = {a[63:3], 3'b000};
      r.be   = wide[7:0];
      r.data = d << (8 * off);
      r.id   = id;
      return r;
   endfunction

   function automatic req_t mk(input logic [63:0] a, input logic [63:0] d,
                               input logic [7:0] be, input logic [19:0] id);
      req_t r;
      r.addr = a; r.data = d; r.be = be; r.id = id;
      return r;
   endfunction

   // Monitor: stalled requests must already show the expected payload;
   // accepted requests pop the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (!err_ok) check("err_quiet", {63'd0, err_o}, 64'd0);
         if (mem_req_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got id 0x%0h addr 0x%0h, expected no request",
                        mem_req_id_o, mem_req_addr_o);
            end else if (mem_req_ready_i) begin
               req_t e;
               e = exp_q.pop_front();
               check("req_addr", mem_req_addr_o, e.addr);
               check("req_data", mem_req_data_o, e.data);
               check("req_be",   {56'd0, mem_req_be_o}, {56'd0, e.be});
               check("req_id",   {44'd0, mem_req_id_o}, {44'd0, e.id});
            end else begin
               check("stall_addr", mem_req_addr_o, exp_q[0].addr);
               check("stall_data", mem_req_data_o, exp_q[0].data);
               check("stall_be",   {56'd0, mem_req_be_o}, {56'd0, exp_q[0].be});
               check("stall_id",   {44'd0, mem_req_id_o}, {44'd0, exp_q[0].id});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) mem_req_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic do_alloc(input logic [19:0] id, output logic [IW-1:0] sq);
      int unsigned n = 0;
      while (!alloc_ready_o && n < 100) begin
         tick();
         n++;
      end
      if (!alloc_ready_o) begin
         checks++;
         errors++;
         $display("FAIL alloc_wait: alloc_ready_o got 0, expected 1 within 100 cycles");
      end
      sq            = alloc_sqid_o;
      alloc_valid_i = 1'b1;
      alloc_id_i    = id;
      tick();
      alloc_valid_i = 1'b0;
   endtask

   task automatic do_exec(input logic [IW-1:0] sq, input logic [63:0] a,
                          input logic [63:0] d, input logic [1:0] s);
      exec_valid_i = 1'b1;
      exec_sqid_i  = sq;
      exec_addr_i  = a;
      exec_data_i  = d;
      exec_size_i  = s;
      tick();
      exec_valid_i = 1'b0;
   endtask

   task automatic do_commit(input logic [NC-1:0] cv);
      commit_valid_i = cv;
      tick();
      commit_valid_i = '0;
   endtask

   task automatic wait_empty(input int unsigned budget);
      int unsigned n = 0;
      while (!empty_o && n < budget) begin
         tick();
         n++;
      end
      check("drain_done", {63'd0, empty_o}, 64'd1);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [IW-1:0] sq;
      logic [IW-1:0] sqs [6];
      logic [1:0]    s;
      logic [63:0]   a, d;
      int unsigned   bytes;

      rst = 1'b1;
      alloc_valid_i = 1'b0; alloc_id_i = '0;
      exec_valid_i = 1'b0; exec_sqid_i = '0; exec_addr_i = '0; exec_data_i = '0; exec_size_i = '0;
      commit_valid_i = '0; flush_i = 1'b0; mem_req_ready_i = 1'b0;
`ifdef STORE_QUEUE_FWD_EN
      ld_valid_i = 1'b0; ld_addr_i = '0; ld_size_i = '0; ld_sqid_i = '0;
`endif
      do_reset();

      // Reset state
      check("rst_alloc_ready", {63'd0, alloc_ready_o}, 64'd1);
      check("rst_alloc_sqid",  {60'd0, alloc_sqid_o}, 64'd0);
      check("rst_mem_valid",   {63'd0, mem_req_valid_o}, 64'd0);
      check("rst_count",       {59'd0, count_o}, 64'd0);
      check("rst_empty",       {63'd0, empty_o}, 64'd1);
      check("rst_full",        {63'd0, full_o}, 64'd0);
      check("rst_err",         {63'd0, err_o}, 64'd0);

      // Fill all 16 slots, then a refused 17th, then flush back to empty
      for (int i = 0; i < 16; i++) begin
         check("fill_sqid", {60'd0, alloc_sqid_o}, 64'(i));
         do_alloc(20'(i), sq);
      end
      check("fill_full",  {63'd0, full_o}, 64'd1);
      check("fill_ready", {63'd0, alloc_ready_o}, 64'd0);
      check("fill_count", {59'd0, count_o}, 64'd16);
      alloc_valid_i = 1'b1; alloc_id_i = 20'hFFFFF;
      tick();
      alloc_valid_i = 1'b0;
      check("over_count", {59'd0, count_o}, 64'd16);
      check("over_sqid",  {60'd0, alloc_sqid_o}, 64'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_all_count", {59'd0, count_o}, 64'd0);
      check("flush_all_empty", {63'd0, empty_o}, 64'd1);

      // Single byte store with back-pressure
      do_alloc(20'd5, sq);
      do_exec(sq, 64'h1003, 64'hAB, 2'd3);
      exp_q.push_back(mk(64'h1000, 64'hAB00_0000, 8'h08, 20'd5));
      do_commit(2'b01);
      check("byte_valid", {63'd0, mem_req_valid_o}, 64'd1);
      tick(); tick(); tick();
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      check("byte_empty", {63'd0, empty_o}, 64'd1);

      // Exec to an unallocated slot and commit with nothing to commit
      err_ok = 1'b1;
      do_exec(4'd3, 64'h0, 64'h0, 2'd0);
      check("exec_unalloc_err", {63'd0, err_o}, 64'd1);
      check("exec_unalloc_cnt", {59'd0, count_o}, 64'd0);
      tick();
      do_commit(2'b01);
      check("commit_excess_err", {63'd0, err_o}, 64'd1);
      tick();
      err_ok = 1'b0;

      // Two-wide commit, rejected non-thermometer pattern
      for (int i = 0; i < 4; i++) do_alloc(20'(100 + i), sqs[i]);
      for (int i = 0; i < 4; i++) do_exec(sqs[i], 64'h3000 + 64'(8 * i), 64'hA0 + 64'(i), 2'd0);
      exp_q.push_back(mk(64'h3000, 64'hA0, 8'hFF, 20'd100));
      exp_q.push_back(mk(64'h3008, 64'hA1, 8'hFF, 20'd101));
      do_commit(2'b11);
      err_ok = 1'b1;
      do_commit(2'b10);
      check("nontherm_err", {63'd0, err_o}, 64'd1);
      tick();
      err_ok = 1'b0;
      exp_q.push_back(mk(64'h3010, 64'hA2, 8'hFF, 20'd102));
      exp_q.push_back(mk(64'h3018, 64'hA3, 8'hFF, 20'd103));
      do_commit(2'b11);
      mem_req_ready_i = 1'b1;
      wait_empty(50);

      // Misaligned word: truncated byte enables, error at acceptance
      do_alloc(20'd77, sq);
      do_exec(sq, 64'h5006, 64'h1122_3344, 2'd1);
      exp_q.push_back(mk(64'h5000, 64'h3344_0000_0000_0000, 8'hC0, 20'd77));
      err_ok = 1'b1;
      do_commit(2'b01);
      tick();
      check("misalign_err", {63'd0, err_o}, 64'd1);
      tick();
      err_ok = 1'b0;
      check("misalign_empty", {63'd0, empty_o}, 64'd1);

      // Reset while a request is pending
      mem_req_ready_i = 1'b0;
      do_alloc(20'd300, sq);
      do_exec(sq, 64'h7000, 64'h55, 2'd0);
      exp_q.push_back(mk(64'h7000, 64'h55, 8'hFF, 20'd300));
      do_commit(2'b01);
      check("pre_rst_valid", {63'd0, mem_req_valid_o}, 64'd1);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {63'd0, mem_req_valid_o}, 64'd0);
      check("async_rst_count", {59'd0, count_o}, 64'd0);
      exp_q.delete();
      do_reset();

      // Flush together with commit; same-cycle alloc ignored
      for (int i = 0; i < 6; i++) do_alloc(20'(200 + i), sqs[i]);
      for (int i = 0; i < 6; i++) do_exec(sqs[i], 64'h6000 + 64'(2 * i), 64'h1000 + 64'(i), 2'd2);
      exp_q.push_back(model(64'h6000, 64'h1000, 2'd2, 20'd200));
      exp_q.push_back(model(64'h6002, 64'h1001, 2'd2, 20'd201));
      do_commit(2'b11);
      exp_q.push_back(model(64'h6004, 64'h1002, 2'd2, 20'd202));
      commit_valid_i = 2'b01; flush_i = 1'b1; alloc_valid_i = 1'b1; alloc_id_i = 20'd999;
      tick();
      commit_valid_i = '0; flush_i = 1'b0; alloc_valid_i = 1'b0;
      check("flush_count", {59'd0, count_o}, 64'd3);
      check("flush_sqid",  {60'd0, alloc_sqid_o}, 64'd3);
      mem_req_ready_i = 1'b1;
      wait_empty(50);

      // 40 mixed stores with random ready; pointers wrap twice
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s     = 2'(i % 4);
         bytes = 8 >> s;
         a     = 64'h8000 + 64'(16 * i) + 64'((i * bytes) % 8);
         d     = {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h0101_0101};
         do_alloc(20'(1000 + i), sq);
         do_exec(sq, a, d, s);
         exp_q.push_back(model(a, d, s, 20'(1000 + i)));
         do_commit(2'b01);
      end
      rand_ready = 1'b0;
      mem_req_ready_i = 1'b1;
      wait_empty(200);

`ifdef STORE_QUEUE_FWD_EN
      do_reset();
      mem_req_ready_i = 1'b0;
      do_alloc(20'd7, sq);
      do_exec(sq, 64'h2000, 64'hDEAD_BEEF, 2'd1);
      ld_valid_i = 1'b1; ld_sqid_i = 5'd1; ld_addr_i = 64'h2002; ld_size_i = 2'd2;
      #1;
      check("fwd_h_hit",  {63'd0, fwd_hit_o}, 64'd1);
      check("fwd_h_full", {63'd0, fwd_full_o}, 64'd1);
      check("fwd_h_data", {48'd0, fwd_data_o[15:0]}, 64'hDEAD);
      ld_addr_i = 64'h2000; ld_size_i = 2'd0;
      #1;
      check("fwd_d_hit",  {63'd0, fwd_hit_o}, 64'd1);
      check("fwd_d_full", {63'd0, fwd_full_o}, 64'd0);
      ld_sqid_i = 5'd0;
      #1;
      check("fwd_older_hit", {63'd0, fwd_hit_o}, 64'd0);
      ld_valid_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised in-order store queue for the out-of-order core, indexed by sq_id_t.
- Allocates at dispatch, captures address/data at LSU execute, marks entries committed from the ROB, and drains committed stores to the data memory port.
- Successor to the fixed 16-entry, single-commit-port configuration: depth and commit width are generic, flush of speculative entries is supported, and store-to-load forwarding is optional.

Parameters:
- NR_ENTRIES, 16, queue depth; power of two, >= 2.
- NR_COMMIT_PORTS, 1, stores committable per cycle; range 1..NR_ENTRIES.
- XLEN, 64, data/address width.
- ID_BITS, 20, instruction id width.
- IDX_W, $clog2(NR_ENTRIES), derived entry index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- alloc_valid_i  in  1  dispatch requests one entry.
- alloc_id_i  in  ID_BITS  instruction id stored with the entry.
- alloc_ready_o  out  1  entry available.
- alloc_sqid_o  out  IDX_W  index granted (current tail).
- exec_valid_i  in  1  LSU delivers address/data.
- exec_sqid_i  in  IDX_W  target entry.
- exec_addr_i  in  XLEN  byte address.
- exec_data_i  in  XLEN  store data, LSB-aligned.
- exec_size_i  in  2  SIZE_D=0, SIZE_W=1, SIZE_H=2, SIZE_B=3.
- commit_valid_i  in  NR_COMMIT_PORTS  thermometer; bit k commits the k-th oldest uncommitted entry.
- flush_i  in  1  discard all uncommitted entries.
- mem_req_valid_o  out  1  store request.
- mem_req_ready_i  in  1  memory accepts.
- mem_req_addr_o  out  XLEN  address with bits [2:0] cleared.
- mem_req_data_o  out  XLEN  data shifted to its byte lane.
- mem_req_be_o  out  XLEN/8  byte enables.
- mem_req_id_o  out  ID_BITS  id of the draining store.
- count_o  out  IDX_W+1  occupied entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == NR_ENTRIES.
- err_o  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- State and reset:
  - Circular buffer with pointers head (oldest), cmt (oldest uncommitted) and tail (next free), each IDX_W+1 bits with a wrap bit.
  - Per-entry flags: executed, committed.
  - Reset clears pointers and flags. Outputs at reset: alloc_ready_o=1, alloc_sqid_o=0, mem_req_valid_o=0, count_o=0, empty_o=1, full_o=0, err_o=0.
  - Reset mid-drain drops mem_req_valid_o immediately (asynchronous).
- Alloc:
  - alloc_ready_o = !full_o, computed from registered state only. No same-cycle reuse of a slot freed by drain.
  - On alloc_valid_i && alloc_ready_o: store alloc_id_i, clear both flags, increment tail. New index is visible next cycle.
- Exec:
  - On exec_valid_i: set executed and capture addr/data/size, no earlier than the cycle after alloc.
  - Exec to an entry that is not allocated-and-uncommitted: pulse err_o; the write is ignored.
- Commit:
  - Let n = popcount(commit_valid_i). Mark n entries from cmt as committed; cmt += n.
  - Non-thermometer pattern: pulse err_o, no update.
  - Committing a non-executed entry: pulse err_o, entry still committed.
  - cmt never passes tail; any excess pulses err_o and is clamped.
- Drain:
  - mem_req_valid_o = head entry committed && executed (registered-state combinational).
  - Byte enables: be = mask(size) << addr[2:0], with mask D=0xFF, W=0x0F, H=0x03, B=0x01.
  - Data: data << (8*addr[2:0]).
  - Misaligned (addr not a multiple of the size): pulse err_o, request still issued with the truncated be.
  - Handshake: on valid&&ready, head increments next edge. valid holds with stable payload until ready.
- Flush:
  - tail <= cmt, discarding uncommitted entries. Committed entries still drain.
  - Same-cycle ordering: commit applies first, then flush, so tail = updated cmt. Alloc in the same cycle is ignored.
- Simultaneous alloc and drain: both apply; count_o unchanged.
- Wrap-around: index = pointer[IDX_W-1:0]; full when indices are equal and wrap bits differ.

Optional Feature:
- Macro: STORE_QUEUE_FWD_EN.
- When defined, adds ports:
  - ld_valid_i (1), ld_addr_i (XLEN), ld_size_i (2), ld_sqid_i (IDX_W+1, tail snapshot at load dispatch).
  - fwd_hit_o (1), fwd_full_o (1), fwd_data_o (XLEN).
- Forwarding rules, combinational:
  - Search executed entries older than ld_sqid_i, from head up to ld_sqid_i, including committed ones not yet drained.
  - An entry matches when addr[XLEN-1:3] is equal and byte enables overlap.
  - fwd_hit_o = any match.
  - fwd_full_o = youngest match's be covers the load's be.
  - fwd_data_o = youngest match's data shifted right by 8*ld_addr_i[2:0].
- When undefined: ports absent, no search logic.

Test Plan:
- Reset, then alloc 16 with no commits -> alloc_sqid_o 0..15; full_o=1 after the 16th; alloc_ready_o=0; 17th request ignored; count_o=16.
- Alloc id 5; exec addr 0x1003, data 0xAB, SIZE_B; commit -> mem_req_valid_o next cycle; addr 0x1000, be 0x08, data 0xAB000000. With ready low 3 cycles the payload is stable; on accept, empty_o=1.
- NR_COMMIT_PORTS=2: alloc 4, exec all, commit_valid_i=2'b11 -> two entries drain in order. commit_valid_i=2'b10 -> err_o pulse, no commit.
- Alloc 6, commit 2, flush_i together with commit 1 -> 3 entries remain, count_o=3, tail index 3, next alloc_sqid_o=3.
- Fill and drain 40 stores with random ready -> pointers wrap twice; mem_req_id_o order matches alloc order; no err_o.
- STORE_QUEUE_FWD_EN: store SIZE_W 0xDEADBEEF @0x2000, load SIZE_H @0x2002 -> fwd_hit_o=1, fwd_full_o=1, fwd_data_o[15:0]=0xDEAD. Load SIZE_D @0x2000 -> fwd_full_o=0.
